// File: rtl/rr_tdm_pkg.sv
// Package: rr_tdm_pkg
// Shared types and helpers for the round-robin TDM multiply engine.
//   ch_idx_t    channel index for the default four-channel build
//   coef_dir_e  coefficient counter direction
//   next_coef   one step of a coefficient counter; the caller truncates
//               the result to its own width, so wrap is modulo 2**COEF_W
//   PIPE_LAT    pop-to-output latency in cycles when not stalled
package rr_tdm_pkg;

  localparam int PIPE_LAT   = 3;
  localparam int DEF_NUM_CH = 4;

  typedef logic [$clog2(DEF_NUM_CH)-1:0] ch_idx_t;

  typedef enum logic {
    COEF_UP   = 1'b0,
    COEF_DOWN = 1'b1
  } coef_dir_e;

  function automatic logic [31:0] next_coef(coef_dir_e dir, logic [31:0] val);
    return (dir == COEF_DOWN) ? (val - 32'd1) : (val + 32'd1);
  endfunction

endpackage

// File: rtl/rr_tdm_mac_fifo.sv
// Module: tdm_ch_fifo
// Per-channel synchronous FIFO with first-word fall-through read data.
// A full FIFO refuses a push even when a pop happens in the same cycle.
// Ports:
//   clk    system clock
//   rst    synchronous active-low reset; empties the FIFO
//   push   write din (ignored when full)
//   pop    advance the read pointer (ignored when empty)
//   din    write data
//   dout   head-of-queue data, valid whenever empty==0
//   full   FIFO_DEPTH entries held
//   empty  no entries held
module tdm_ch_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rr_tdm_mac.sv
// Module: rr_tdm_mac
// N-channel round-robin TDM multiply engine. Each channel has its own input
// FIFO and coefficient counter; a slot scheduler picks one channel per cycle
// and feeds a shared three-stage multiplier pipeline with a tagged output.
//
// Build option:
//   RR_TDM_SKIP_IDLE_EN  undefined: strict TDM, every slot visited in turn and
//                        empty slots become pipeline bubbles.
//                        defined: work-conserving, the grant goes to the first
//                        non-empty channel at or after the slot pointer.
//
// Ports:
//   clk      system clock
//   rst      synchronous active-low reset
//   s_valid  per-channel sample valid
//   s_data   per-channel samples, channel c at [c*DATA_W +: DATA_W]
//   s_ready  per-channel FIFO not full (low while in reset)
//   m_valid  product valid
//   m_data   sample * coefficient, full width
//   m_ch     source channel of m_data
//   m_ready  downstream accept
module rr_tdm_mac
  import rr_tdm_pkg::*;
#(
  parameter int                NUM_CH     = 4,
  parameter int                DATA_W     = 8,
  parameter int                COEF_W     = 8,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [NUM_CH-1:0] COEF_DIR   = NUM_CH'(4'b1010)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          s_valid,
  input  logic [NUM_CH*DATA_W-1:0]   s_data,
  output logic [NUM_CH-1:0]          s_ready,
  output logic                       m_valid,
  output logic [DATA_W+COEF_W-1:0]   m_data,
  output logic [$clog2(NUM_CH)-1:0]  m_ch,
  input  logic                       m_ready
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int PW   = DATA_W + COEF_W;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic                en;
  logic [NUM_CH-1:0]   fifo_full;
  logic [NUM_CH-1:0]   fifo_empty;
  logic [NUM_CH-1:0]   fifo_push;
  logic [NUM_CH-1:0]   fifo_pop;
  logic [DATA_W-1:0]   fifo_dout [NUM_CH];
  logic [COEF_W-1:0]   coef_q [NUM_CH];

  logic [CH_W-1:0]     ptr_q;
  logic [CH_W-1:0]     ptr_d;
  logic [CH_W-1:0]     grant;
  logic                grant_vld;

  logic                s1_valid;
  logic [DATA_W-1:0]   s1_data;
  logic [COEF_W-1:0]   s1_coef;
  logic [CH_W-1:0]     s1_ch;

  logic                s2_valid;
  logic [PW-1:0]       s2_prod;
  logic [CH_W-1:0]     s2_ch;

  function automatic logic [CH_W-1:0] ch_inc(logic [CH_W-1:0] c);
    return (c == LAST_CH) ? '0 : (c + 1'b1);
  endfunction

  // The whole engine, scheduler included, freezes while the output register
  // holds a product nobody has taken.
  assign en = !(m_valid && !m_ready);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign s_ready[c]   = rst && !fifo_full[c];
    assign fifo_push[c] = s_valid[c] && s_ready[c];
    assign fifo_pop[c]  = en && grant_vld && (grant == CH_W'(c));

    tdm_ch_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push[c]),
      .pop   (fifo_pop[c]),
      .din   (s_data[c*DATA_W +: DATA_W]),
      .dout  (fifo_dout[c]),
      .full  (fifo_full[c]),
      .empty (fifo_empty[c])
    );
  end

`ifdef RR_TDM_SKIP_IDLE_EN
  logic [CH_W-1:0] idx;

  // Cyclic first-non-empty search starting at the slot pointer. With nothing
  // pending the pointer stays put so the next arrival is served from there.
  always_comb begin
    grant     = ptr_q;
    grant_vld = 1'b0;
    ptr_d     = ptr_q;
    idx       = ptr_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!grant_vld && !fifo_empty[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
      idx = ch_inc(idx);
    end
    if (grant_vld) begin
      ptr_d = ch_inc(grant);
    end
  end
`else
  // Strict TDM: the slot pointer alone decides; an empty slot is a bubble.
  always_comb begin
    grant     = ptr_q;
    grant_vld = !fifo_empty[ptr_q];
    ptr_d     = ch_inc(ptr_q);
  end
`endif

  // Scheduler state and coefficient counters. A counter steps only when its
  // channel actually issues a sample, and wraps silently.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        coef_q[c] <= {COEF_W{COEF_DIR[c]}};
      end
    end else if (en) begin
      ptr_q <= ptr_d;
      for (int c = 0; c < NUM_CH; c++) begin
        if (grant_vld && (grant == CH_W'(c))) begin
          coef_q[c] <= COEF_W'(next_coef(coef_dir_e'(COEF_DIR[c]), 32'(coef_q[c])));
        end
      end
    end
  end

  // S1 issue, S2 product, S3 output. Operands are widened before the
  // multiply so the full DATA_W+COEF_W product is kept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_coef  <= '0;
      s1_ch    <= '0;
      s2_valid <= 1'b0;
      s2_prod  <= '0;
      s2_ch    <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_ch     <= '0;
    end else if (en) begin
      s1_valid <= grant_vld;
      s1_data  <= fifo_dout[grant];
      s1_coef  <= coef_q[grant];
      s1_ch    <= grant;

      s2_valid <= s1_valid;
      s2_prod  <= PW'(s1_data) * PW'(s1_coef);
      s2_ch    <= s1_ch;

      // Bubbles leave the last product on m_data/m_ch.
      m_valid  <= s2_valid;
      if (s2_valid) begin
        m_data <= s2_prod;
        m_ch   <= s2_ch;
      end
    end
  end

endmodule
